// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the target and the team's controller.
package i2c_pkg;

  // Target protocol states.
  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus bus edge and START/STOP detection.
// Index [1] of each pipe is the synchronized level, index [2] is the previous
// synchronized level used for edge detection.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Shift the raw lines through the synchronizer and history flops; an idle
  // bus is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target with an auto-incrementing register pointer.
//
// state     | meaning
// IDLE      | bus free or not yet started
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving ACK for matched address
// PTR       | shifting in register pointer
// PTR_ACK   | driving ACK for pointer byte
// WDATA     | shifting in a write data byte
// WDATA_ACK | driving ACK for write data
// RDATA     | shifting out a read byte
// RDATA_ACK | sampling the controller's ACK/NACK
// IGNORE    | not addressed / read ended; wait for START or STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h55
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_en_q, rd_en_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       busy_q, busy_d;
  logic       ld_q;
  logic [7:0] byte_in;

  assign byte_in = {shift_q[6:0], sda_s};

  // State and datapath registers; SDA release on reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      ld_q      <= rd_en_q;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit handling.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;

    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      // Register-file data arrives the cycle after rd_en; present MSB at once.
      if (ld_q && state_q == RDATA) begin
        shift_d  = rd_data;
        sda_oe_d = ~rd_data[7];
      end
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d = IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == PTR) begin
                ptr_d   = byte_in;
                state_d = PTR_ACK;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = ptr_q + 8'd1;
                state_d   = WDATA_ACK;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // First falling edge starts the ACK, the second one ends it.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              if (state_q == ADDR_ACK && shift_q[0] == I2C_READ) begin
                state_d   = RDATA;
                rd_en_d   = 1'b1;
                rd_addr_d = ptr_q;
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              ptr_d    = ptr_q + 8'd1;
              state_d  = RDATA_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_NACK) state_d = IGNORE;
          end else if (scl_fall) begin
            state_d   = RDATA;
            rd_en_d   = 1'b1;
            rd_addr_d = ptr_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller, register-file model and a
// scoreboard of expected write/read strobes.
module tb_i2c_target;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_tb, sda_tb;
  logic       sda_line;
  logic       sda_oe, wr_en, rd_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0] mem [256];

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_wr[$], obs_wr[$];
  logic [7:0]  exp_rd[$], obs_rd[$];
  int cyc = 0, rise_cyc = 0, wr_lat = -1;
  logic oe_seen, busy_seen;

  assign sda_line = sda_tb & ~sda_oe;

  i2c_target #(.DEV_ADDR(7'h55)) dut (
    .clk     (clk),
    .reset   (reset),
    .scl_i   (scl_tb),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // register-file read port: data valid the cycle after rd_en
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // observe strobes away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (dut.scl_rise) rise_cyc = cyc;
    if (wr_en) begin
      obs_wr.push_back({wr_addr, wr_data});
      wr_lat = cyc - rise_cyc;
    end
    if (rd_en) obs_rd.push_back(rd_addr);
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
  endtask

  task automatic clear_sb();
    exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
    oe_seen = 1'b0; busy_seen = 1'b0; wr_lat = -1;
  endtask

  task automatic i2c_start();
    wait_clk(2); sda_tb = 1'b1; wait_clk(8); scl_tb = 1'b1;
    wait_clk(10); sda_tb = 1'b0; wait_clk(10); scl_tb = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(2); sda_tb = 1'b0; wait_clk(8); scl_tb = 1'b1;
    wait_clk(10); sda_tb = 1'b1; wait_clk(10);
  endtask

  task automatic write_bit(input logic b);
    wait_clk(2); sda_tb = b; wait_clk(8); scl_tb = 1'b1;
    wait_clk(10); scl_tb = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    wait_clk(2); sda_tb = 1'b1; wait_clk(8); scl_tb = 1'b1;
    wait_clk(5); ack = sda_line; wait_clk(5); scl_tb = 1'b0;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      wait_clk(2); sda_tb = 1'b1; wait_clk(8); scl_tb = 1'b1;
      wait_clk(5); d[i] = sda_line; wait_clk(5); scl_tb = 1'b0;
    end
    wait_clk(2); sda_tb = mack; wait_clk(8); scl_tb = 1'b1;
    wait_clk(10); scl_tb = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 8;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (wr_addr !== 8'h00) begin failures++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
    if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    if (rd_addr !== 8'h00) begin failures++; $display("FAIL reset_rd_addr got=%h exp=00", rd_addr); end
    if (dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state_q); end
  endtask

  task automatic test_write();
    logic ack;
    logic [7:0] bytes [4];
    bytes[0] = 8'hAA; bytes[1] = 8'h55; bytes[2] = 8'h77; bytes[3] = 8'h22;
    clear_sb();
    exp_wr.push_back({8'h55, 8'h77});
    exp_wr.push_back({8'h56, 8'h22});
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], ack);
      checks++;
      if (ack !== I2C_ACK) begin failures++; $display("FAIL write_ack byte%0d got=%b exp=0", i, ack); end
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL write_busy got=%b exp=1", busy); end
    i2c_stop();
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_after_stop got=%b exp=0", busy); end
    if (dut.ptr_q !== 8'h57) begin failures++; $display("FAIL write_ptr got=%h exp=57", dut.ptr_q); end
    if (wr_lat !== 1) begin failures++; $display("FAIL write_wr_en_latency got=%0d exp=1", wr_lat); end
    if (obs_wr.size() != exp_wr.size()) begin failures++; $display("FAIL write_count got=%0d exp=%0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      logic [15:0] e, o;
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL write_strobe got=%h/%h exp=%h/%h", o[15:8], o[7:0], e[15:8], e[7:0]); end
    end
  endtask

  task automatic test_mismatch();
    logic ack;
    clear_sb();
    i2c_start();
    write_byte({7'h54, I2C_WRITE}, ack);
    checks++;
    if (ack !== I2C_NACK) begin failures++; $display("FAIL mismatch_addr_ack got=%b exp=1", ack); end
    write_byte(8'h10, ack);
    checks++;
    if (ack !== I2C_NACK) begin failures++; $display("FAIL mismatch_data_ack got=%b exp=1", ack); end
    i2c_stop();
    checks += 3;
    if (oe_seen !== 1'b0) begin failures++; $display("FAIL mismatch_sda_oe got=%b exp=0", oe_seen); end
    if (obs_wr.size() != 0) begin failures++; $display("FAIL mismatch_wr_count got=%0d exp=0", obs_wr.size()); end
    if (busy_seen !== 1'b0) begin failures++; $display("FAIL mismatch_busy got=%b exp=0", busy_seen); end
  endtask

  task automatic test_read_rs();
    logic ack;
    logic [7:0] d;
    clear_sb();
    mem[8'h55] = 8'hAA;
    exp_rd.push_back(8'h55);
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h55, ack);
    i2c_start();
    write_byte(8'hAB, ack);
    checks++;
    if (ack !== I2C_ACK) begin failures++; $display("FAIL read_addr_ack got=%b exp=0", ack); end
    read_byte(I2C_NACK, d);
    checks++;
    if (d !== 8'hAA) begin failures++; $display("FAIL read_data got=%h exp=aa", d); end
    wait_clk(4);
    checks++;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL read_release got=%b exp=0", sda_oe); end
    i2c_stop();
    checks += 2;
    if (obs_wr.size() != 0) begin failures++; $display("FAIL read_wr_count got=%0d exp=0", obs_wr.size()); end
    if (obs_rd.size() != exp_rd.size()) begin failures++; $display("FAIL read_rd_count got=%0d exp=%0d", obs_rd.size(), exp_rd.size()); end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      logic [7:0] e, o;
      e = exp_rd.pop_front(); o = obs_rd.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL read_rd_addr got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_multi_read();
    logic ack;
    logic [7:0] d;
    logic [7:0] exp_d [3];
    logic       mack [3];
    clear_sb();
    mem[8'hFE] = 8'hC3; mem[8'hFF] = 8'h81; mem[8'h00] = 8'h7E;
    exp_d[0] = 8'hC3; exp_d[1] = 8'h81; exp_d[2] = 8'h7E;
    mack[0] = I2C_ACK; mack[1] = I2C_ACK; mack[2] = I2C_NACK;
    exp_rd.push_back(8'hFE); exp_rd.push_back(8'hFF); exp_rd.push_back(8'h00);
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'hFE, ack);
    i2c_start();
    write_byte(8'hAB, ack);
    for (int i = 0; i < 3; i++) begin
      read_byte(mack[i], d);
      checks++;
      if (d !== exp_d[i]) begin failures++; $display("FAIL mread_data byte%0d got=%h exp=%h", i, d, exp_d[i]); end
    end
    i2c_stop();
    checks++;
    if (obs_rd.size() != exp_rd.size()) begin failures++; $display("FAIL mread_rd_count got=%0d exp=%0d", obs_rd.size(), exp_rd.size()); end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      logic [7:0] e, o;
      e = exp_rd.pop_front(); o = obs_rd.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL mread_rd_addr got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_abort();
    logic ack;
    clear_sb();
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h10, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    checks += 4;
    if (obs_wr.size() != 0) begin failures++; $display("FAIL abort_wr_count got=%0d exp=0", obs_wr.size()); end
    if (dut.state_q !== IDLE) begin failures++; $display("FAIL abort_state got=%0d exp=IDLE", dut.state_q); end
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL abort_sda_oe got=%b exp=0", sda_oe); end
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_during_ack();
    logic ack;
    logic [7:0] b;
    clear_sb();
    b = 8'hAA;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    wait_clk(5);
    checks++;
    if (sda_oe !== 1'b1) begin failures++; $display("FAIL rst_ack_driving got=%b exp=1", sda_oe); end
    reset = 1'b1;
    #1;
    checks++;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL rst_async_release got=%b exp=0", sda_oe); end
    wait_clk(3);
    reset = 1'b0;
    sda_tb = 1'b1;
    wait_clk(4);
    checks += 2;
    if (dut.state_q !== IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=IDLE", dut.state_q); end
    if (dut.ptr_q !== 8'h00) begin failures++; $display("FAIL rst_ptr got=%h exp=00", dut.ptr_q); end
    i2c_start();
    write_byte(8'hAA, ack);
    checks++;
    if (ack !== I2C_ACK) begin failures++; $display("FAIL rst_fresh_ack got=%b exp=0", ack); end
    i2c_stop();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    rd_data = 8'h00;
    scl_tb = 1'b1;
    sda_tb = 1'b1;
    reset = 1'b1;
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    wait_clk(2);
    test_reset();
    test_write();
    test_mismatch();
    test_read_rs();
    test_multi_read();
    test_abort();
    test_reset_during_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
